// File: rtl/gshare_predictor.sv
// gshare_predictor: direct-mapped BTB plus a table of 2-bit saturating
// counters, giving a combinational next-fetch-PC prediction.
// Optional feature macro: GSHARE_PREDICTOR_GSHARE_EN. When it is defined,
// the counter index is hashed with a global history register. When it is
// undefined, the predictor is bimodal and has no history storage.
//
// Interface protocol: the update port is valid-only. When upd_valid is
// high at a rising edge, that edge retires one resolved branch. There is no
// ready signal, so an update is never back-pressured. The read port
// (PC -> predictions) is purely combinational and always available.
module gshare_predictor #(
  parameter int ADDR_W    = 16,
  parameter int PHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int GHR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] NPC_predict,
  output logic              predict_taken,
  output logic              btb_hit,
  output logic [15:0]       mispredict_cnt
);

  localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;

  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [ADDR_W-1:0] btb_target [BTB_N];
  logic [1:0]        pht        [PHT_N];

  // History contribution to the counter index (zero when bimodal).
  logic [PHT_IDX_W-1:0] hist_ext;

`ifdef GSHARE_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // History is advanced only by resolved branches, never speculatively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[GHR_W-2:0], upd_taken};
    end
  end

  assign hist_ext = PHT_IDX_W'(ghr);
`else
  localparam int unused_ghr_w = GHR_W;
  assign hist_ext = '0;
`endif

  // Address bits below the word boundary never select anything.
  logic unused_low_bits;
  assign unused_low_bits = ^{PC[1:0], upd_pc[1:0]};

  // Read-side decode.
  logic [BTB_IDX_W-1:0] rd_btb_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic [PHT_IDX_W-1:0] rd_pht_idx;
  logic [ADDR_W-1:0]    pc_plus4;

  assign rd_btb_idx = PC[BTB_IDX_W+1:2];
  assign rd_tag     = PC[ADDR_W-1:BTB_IDX_W+2];
  assign rd_pht_idx = PC[PHT_IDX_W+1:2] ^ hist_ext;
  assign pc_plus4   = PC + ADDR_W'(4);

  // Update-side decode; uses the pre-edge history.
  logic [BTB_IDX_W-1:0] up_btb_idx;
  logic [TAG_W-1:0]     up_tag;
  logic [PHT_IDX_W-1:0] up_pht_idx;

  assign up_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign up_tag     = upd_pc[ADDR_W-1:BTB_IDX_W+2];
  assign up_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ hist_ext;

  // Combinational prediction from current (pre-edge) table contents.
  always_comb begin
    btb_hit       = btb_valid[rd_btb_idx] && (btb_tag[rd_btb_idx] == rd_tag);
    predict_taken = btb_hit && pht[rd_pht_idx][1];
    NPC_predict   = predict_taken ? btb_target[rd_btb_idx] : pc_plus4;
  end

  // BTB: install/replace on taken branches only; last writer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      btb_valid[up_btb_idx]  <= 1'b1;
      btb_tag[up_btb_idx]    <= up_tag;
      btb_target[up_btb_idx] <= upd_target;
    end
  end

  // Direction counters: saturating train toward the resolved outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (pht[up_pht_idx] != 2'b11) pht[up_pht_idx] <= pht[up_pht_idx] + 2'b01;
      end else begin
        if (pht[up_pht_idx] != 2'b00) pht[up_pht_idx] <= pht[up_pht_idx] - 2'b01;
      end
    end
  end

  // Saturating count of front-end mispredictions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: table-driven vectors through a scoreboard queue,
// followed by hand-written sequences for same-cycle read/update, counter
// saturation and mid-cycle reset.
module tb_gshare_predictor;

  localparam int W = 34; // {btb_hit, predict_taken, NPC_predict, mispredict_cnt}

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [15:0] pc;
  logic [15:0] npc_predict;
  logic        predict_taken;
  logic        btb_hit;
  logic [15:0] mispredict_cnt;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        uv;
    logic [15:0] upc;
    logic [15:0] utgt;
    logic        ut;
    logic        um;
    logic [15:0] rpc;
    logic        hit;
    logic        tk;
    logic [15:0] npc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  gshare_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .PC             (pc),
    .NPC_predict    (npc_predict),
    .predict_taken  (predict_taken),
    .btb_hit        (btb_hit),
    .mispredict_cnt (mispredict_cnt)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic uv, logic [15:0] upc, logic [15:0] utgt, logic ut,
                              logic um, logic [15:0] rpc, logic hit, logic tk,
                              logic [15:0] npc, logic [15:0] cnt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut; v.um = um;
    v.rpc = rpc; v.hit = hit; v.tk = tk; v.npc = npc; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [W-1:0] observed();
    return {btb_hit, predict_taken, npc_predict, mispredict_cnt};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got={hit=%b tk=%b npc=%h cnt=%h} want={hit=%b tk=%b npc=%h cnt=%h}",
               name, got[33], got[32], got[31:16], got[15:0],
               exp[33], exp[32], exp[31:16], exp[15:0]);
    end
  endtask

  // Driver: present one update and read PC, push expectation, compare after the edge.
  task automatic apply_vec(input int idx, input vec_t v);
    logic [W-1:0] e;
    @(negedge clk);
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_target     = v.utgt;
    upd_taken      = v.ut;
    upd_mispredict = v.um;
    pc             = v.rpc;
    exp_q.push_back({v.hit, v.tk, v.npc, v.cnt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx), observed(), e);
  endtask

  task automatic idle_inputs();
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pc    = 16'h0040;
    idle_inputs();

    // Vector table: update (if any) retires at the edge, read checked just after.
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 0, 0, 16'h0044, 16'd0));
`ifdef GSHARE_PREDICTOR_GSHARE_EN
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 0, 16'h0044, 16'd0));
`else
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 1, 16'h0100, 16'd0));
`endif
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0440, 0, 0, 16'h0444, 16'd0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 16'hFFFC, 0, 0, 16'h0000, 16'd0));
`ifdef GSHARE_PREDICTOR_GSHARE_EN
    vecs.push_back(mk(1, 16'h0080, 16'h0200, 1, 1, 16'h0080, 1, 0, 16'h0084, 16'd1));
`else
    vecs.push_back(mk(1, 16'h0080, 16'h0200, 1, 1, 16'h0080, 1, 1, 16'h0200, 16'd1));
`endif
    // 0x0040 was evicted by 0x0080 (same set, different tag).
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 0, 0, 16'h0044, 16'd1));
    // Invalid update carrying a mispredict must change nothing.
    vecs.push_back(mk(0, 16'h0040, 16'h0100, 1, 1, 16'h0040, 0, 0, 16'h0044, 16'd1));
`ifndef GSHARE_PREDICTOR_GSHARE_EN
    // Counter 0x10 is 2: four not-taken drive it to 0 and hold there.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 16'h0040, 16'h0100, 0, 0, 16'h0040, 0, 0, 16'h0044, 16'd1));
    // Taken: counter 1, entry reinstalled -> hit but not predicted taken.
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 0, 16'h0044, 16'd1));
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 1, 16'h0100, 16'd1));
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 1, 16'h0100, 16'd1));
    vecs.push_back(mk(1, 16'h0040, 16'h0100, 1, 0, 16'h0040, 1, 1, 16'h0100, 16'd1));
    // Saturated at 3, one not-taken gives 2; BTB untouched by not-taken.
    vecs.push_back(mk(1, 16'h0040, 16'h0999, 0, 0, 16'h0040, 1, 1, 16'h0100, 16'd1));
`endif

    // Check reset state while reset is held.
    #12;
    check("reset_hold", observed(), {1'b0, 1'b0, 16'h0044, 16'd0});
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Same-cycle read and update of one entry: pre-edge value, then new value.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 16'h00C0; upd_target = 16'h0300;
    upd_taken = 1'b1; upd_mispredict = 1'b0; pc = 16'h00C0;
    #1;
    check("no_bypass_pre", {btb_hit, 33'd0}, {1'b0, 33'd0});
    @(posedge clk);
    #1;
    check("no_bypass_post", {btb_hit, 33'd0}, {1'b1, 33'd0});
`ifndef GSHARE_PREDICTOR_GSHARE_EN
    check("no_bypass_npc", observed(), {1'b1, 1'b1, 16'h0300, 16'd1});
`endif

    // Mispredict counter saturation (starts at 1).
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 16'h1000; upd_target = 16'h0000;
    upd_taken = 1'b0; upd_mispredict = 1'b1; pc = 16'h00C0;
    exp_q.push_back({18'd0, 16'hFFFE});
    repeat (16'hFFFD) @(posedge clk);
    #1;
    check("cnt_fffe", {18'd0, mispredict_cnt}, exp_q.pop_front());
    exp_q.push_back({18'd0, 16'hFFFF});
    @(posedge clk);
    #1;
    check("cnt_ffff", {18'd0, mispredict_cnt}, exp_q.pop_front());
    exp_q.push_back({18'd0, 16'hFFFF});
    repeat (2) @(posedge clk);
    #1;
    check("cnt_hold", {18'd0, mispredict_cnt}, exp_q.pop_front());

    // Reset mid-cycle with a taken update presented: immediate clear, update dropped.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 16'h00C0; upd_target = 16'h0300;
    upd_taken = 1'b1; upd_mispredict = 1'b1; pc = 16'h00C0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", observed(), {1'b0, 1'b0, 16'h00C4, 16'd0});
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    check("rst_discard", observed(), {1'b0, 1'b0, 16'h00C4, 16'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
